// File: rtl/reed_solomon_decoder_pkg.sv
// Shared definitions for the Reed-Solomon decoder datapath.
// Provides the line geometry used by the line-oriented write-back path:
//   RS_LINE_BYTES / RS_LINE_BITS : size of one write-back line
//   RS_LANE_BITS                 : width of a byte-lane index within a line
//   rs_line_t / rs_byte_en_t     : one line of data / one byte-enable per lane
package reed_solomon_decoder_pkg;

  localparam int RS_LINE_BYTES = 64;
  localparam int RS_LINE_BITS  = 512;
  localparam int RS_LANE_BITS  = 6;

  typedef logic [RS_LINE_BITS-1:0]  rs_line_t;
  typedef logic [RS_LINE_BYTES-1:0] rs_byte_en_t;

endpackage

// File: rtl/reed_solomon_decoder_pack_line_ram.sv
// Line storage for the byte-to-line packing FIFO.
// 2**AW lines of 512 bits, one synchronous write port with a byte-write
// enable per lane, one asynchronous (combinational) read port.
// Ports:
//   clk        : clock, writes on rising edge
//   wr_addr_i  : line index to write
//   wr_be_i    : per-lane write enable, lane i covers wr_data_i[8*i +: 8]
//   wr_data_i  : write data
//   rd_addr_i  : line index to read
//   rd_data_o  : contents of line rd_addr_i (no register on the read path)
// Contents are intentionally not reset.
module reed_solomon_decoder_pack_line_ram
  import reed_solomon_decoder_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic [AW-1:0] wr_addr_i,
  input  rs_byte_en_t   wr_be_i,
  input  rs_line_t      wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output rs_line_t      rd_data_o
);

  localparam int LINES = 1 << AW;

  rs_line_t mem_q [LINES];

  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_LINE_BYTES; i++) begin
      if (wr_be_i[i]) begin
        mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/reed_solomon_decoder_pack_fifo.sv
// Byte-to-line packing FIFO behind the Reed-Solomon decoder core.
// Bytes arrive one per cycle and are packed into 64-byte (512-bit) lines;
// complete lines are popped one per cycle. A flush closes the current
// partial line by zero-padding it up to the next 64-byte boundary.
//
// Handshake semantics: an enqueue is accepted in a cycle where enq_en and
// not_full are both high at the rising edge; a dequeue is accepted where
// deq_en and not_empty are both high. not_full/not_empty reflect the
// registered state of the current cycle only, so both may be accepted in
// the same cycle. A request that is not accepted changes nothing except
// setting the matching sticky error flag (overflow / underflow).
//
// Ports:
//   clk, reset          : clock; synchronous active-high reset
//   enq_data, enq_en    : byte input and its write request
//   flush               : zero-pad the current partial line (after any
//                         same-cycle enqueue)
//   not_full            : at least one byte free
//   deq_data            : line at the read pointer, byte i in [8*i +: 8]
//   deq_en              : pop one line
//   not_empty           : at least one complete line buffered
//   counter, free_count : bytes buffered (including pad) and bytes free
//   overflow, underflow : sticky error flags
module reed_solomon_decoder_pack_fifo
  import reed_solomon_decoder_pkg::*;
#(
  parameter int REED_SOLOMON_DECODER_PACK_FIFO_DEPTH = 512
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [7:0]                                           enq_data,
  input  logic                                                 enq_en,
  input  logic                                                 flush,
  output logic                                                 not_full,
  output logic [RS_LINE_BITS-1:0]                              deq_data,
  input  logic                                                 deq_en,
  output logic                                                 not_empty,
  output logic [$clog2(REED_SOLOMON_DECODER_PACK_FIFO_DEPTH):0] counter,
  output logic [$clog2(REED_SOLOMON_DECODER_PACK_FIFO_DEPTH):0] free_count,
  output logic                                                 overflow,
  output logic                                                 underflow
);

  localparam int DEPTH = REED_SOLOMON_DECODER_PACK_FIFO_DEPTH;
  localparam int AW    = $clog2(DEPTH);       // byte pointer width
  localparam int CW    = AW + 1;              // counter width
  localparam int LAW   = AW - RS_LANE_BITS;   // line pointer width

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  counter_q, counter_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  logic                    enq_acc;
  logic                    deq_acc;
  logic [AW-1:0]           wr_after_enq;
  logic [RS_LANE_BITS-1:0] pad_off;
  logic                    pad_en;
  logic [6:0]              pad_cnt;
  rs_byte_en_t             wr_be;
  rs_line_t                wr_line;

  // Status is derived only from the registered byte count.
  assign not_full   = (counter_q < CW'(DEPTH));
  assign not_empty  = (counter_q >= CW'(RS_LINE_BYTES));
  assign free_count = CW'(DEPTH) - counter_q;
  assign counter    = counter_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  assign enq_acc = enq_en && not_full;
  assign deq_acc = deq_en && not_empty;

  // Padding starts after any same-cycle enqueue. If that byte lands in
  // lane 63 the post-enqueue offset wraps to 0 and no pad is needed.
  // Whenever pad_en is set the offset did not wrap, so the enqueued byte
  // and all pad lanes live in the same line, wr_ptr_q's line.
  assign wr_after_enq = wr_ptr_q + AW'(enq_acc);
  assign pad_off      = wr_after_enq[RS_LANE_BITS-1:0];
  assign pad_en       = flush && (pad_off != '0);
  assign pad_cnt      = pad_en ? (7'd64 - {1'b0, pad_off}) : 7'd0;

  always_comb begin
    wr_be   = '0;
    wr_line = '0;
    for (int i = 0; i < RS_LINE_BYTES; i++) begin
      if (pad_en && (RS_LANE_BITS'(i) >= pad_off)) begin
        wr_be[i]          = 1'b1;
        wr_line[8*i +: 8] = 8'h00;
      end else begin
        wr_be[i]          = enq_acc && (wr_ptr_q[RS_LANE_BITS-1:0] == RS_LANE_BITS'(i));
        wr_line[8*i +: 8] = enq_data;
      end
    end
  end

  always_comb begin
    wr_ptr_d    = wr_after_enq + AW'(pad_cnt);
    rd_ptr_d    = rd_ptr_q + LAW'(deq_acc);
    counter_d   = counter_q + CW'(enq_acc) + CW'(pad_cnt)
                  - (deq_acc ? CW'(RS_LINE_BYTES) : CW'(0));
    overflow_d  = overflow_q  || (enq_en && !not_full);
    underflow_d = underflow_q || (deq_en && !not_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      counter_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      counter_q   <= counter_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Writes during reset are blocked so a reset mid-line leaves no partial
  // state behind except stale memory, which is never exposed as valid.
  reed_solomon_decoder_pack_line_ram #(
    .AW (LAW)
  ) u_line_ram (
    .clk       (clk),
    .wr_addr_i (wr_ptr_q[AW-1:RS_LANE_BITS]),
    .wr_be_i   (reset ? '0 : wr_be),
    .wr_data_i (wr_line),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (deq_data)
  );

endmodule

// File: tb/tb_reed_solomon_decoder_pack_fifo.sv
module tb_reed_solomon_decoder_pack_fifo;
  import reed_solomon_decoder_pkg::*;

  localparam int DEPTH = 512;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    enq_data;
  logic          enq_en;
  logic          flush;
  logic          not_full;
  rs_line_t      deq_data;
  logic          deq_en;
  logic          not_empty;
  logic [CW-1:0] counter;
  logic [CW-1:0] free_count;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  reed_solomon_decoder_pack_fifo #(
    .REED_SOLOMON_DECODER_PACK_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enq_data   (enq_data),
    .enq_en     (enq_en),
    .flush      (flush),
    .not_full   (not_full),
    .deq_data   (deq_data),
    .deq_en     (deq_en),
    .not_empty  (not_empty),
    .counter    (counter),
    .free_count (free_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  bit         m_ovf;
  bit         m_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input rs_line_t act, input rs_line_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rs_line_t model_head();
    rs_line_t l = '0;
    for (int i = 0; i < RS_LINE_BYTES; i++) l[8*i +: 8] = exp_q[i];
    return l;
  endfunction

  task automatic model_check(input string tag);
    int sz = exp_q.size();
    chk({tag, ".counter"},    32'(counter),    32'(sz));
    chk({tag, ".free_count"}, 32'(free_count), 32'(DEPTH - sz));
    chk({tag, ".not_full"},   32'(not_full),   32'(sz < DEPTH));
    chk({tag, ".not_empty"},  32'(not_empty),  32'(sz >= 64));
    chk({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
    chk({tag, ".underflow"},  32'(underflow),  32'(m_udf));
    if (sz >= 64) chk_line({tag, ".deq_data"}, deq_data, model_head());
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit e, input logic [7:0] d, input bit f, input bit q,
                       input string tag);
    int  sz = exp_q.size();
    bit  acc_e = e && (sz < DEPTH);
    bit  acc_d = q && (sz >= 64);
    enq_en = e; enq_data = d; flush = f; deq_en = q;
    if (e && !acc_e) m_ovf = 1'b1;
    if (q && !acc_d) m_udf = 1'b1;
    if (acc_d) repeat (64) void'(exp_q.pop_front());
    if (acc_e) exp_q.push_back(d);
    // read pointer is line aligned, so size mod 64 is the write offset
    if (f && (exp_q.size() % 64) != 0) begin
      int pad = 64 - (exp_q.size() % 64);
      repeat (pad) exp_q.push_back(8'h00);
    end
    @(posedge clk); #1;
    enq_en = 1'b0; flush = 1'b0; deq_en = 1'b0;
    model_check(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    chk({tag, ".rst_counter"},   32'(counter),    32'd0);
    chk({tag, ".rst_free"},      32'(free_count), 32'(DEPTH));
    chk({tag, ".rst_not_full"},  32'(not_full),   32'd1);
    chk({tag, ".rst_not_empty"}, 32'(not_empty),  32'd0);
    chk({tag, ".rst_overflow"},  32'(overflow),   32'd0);
    chk({tag, ".rst_underflow"}, 32'(underflow),  32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         e;
    logic [7:0] d;
    bit         f;
    bit         q;
    int         exp_cnt;
    bit         exp_ne;
    bit         exp_udf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rs_line_t exp_line;

    tbl[0] = '{e:0, d:8'h00, f:0, q:1, exp_cnt:0,  exp_ne:0, exp_udf:1}; // pop empty
    tbl[1] = '{e:1, d:8'hA1, f:0, q:0, exp_cnt:1,  exp_ne:0, exp_udf:1};
    tbl[2] = '{e:1, d:8'hA2, f:0, q:0, exp_cnt:2,  exp_ne:0, exp_udf:1};
    tbl[3] = '{e:0, d:8'h00, f:1, q:0, exp_cnt:64, exp_ne:1, exp_udf:1}; // pad 62
    tbl[4] = '{e:1, d:8'hB0, f:0, q:1, exp_cnt:1,  exp_ne:0, exp_udf:1}; // enq+deq
    tbl[5] = '{e:1, d:8'hB1, f:1, q:0, exp_cnt:64, exp_ne:1, exp_udf:1}; // enq+flush
    tbl[6] = '{e:0, d:8'h00, f:1, q:0, exp_cnt:64, exp_ne:1, exp_udf:1}; // flush at 0
    tbl[7] = '{e:0, d:8'h00, f:0, q:1, exp_cnt:0,  exp_ne:0, exp_udf:1};
    tbl[8] = '{e:0, d:8'h00, f:0, q:1, exp_cnt:0,  exp_ne:0, exp_udf:1};

    reset = 1'b1; enq_data = '0; enq_en = 1'b0; flush = 1'b0; deq_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].e, tbl[i].d, tbl[i].f, tbl[i].q, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.cnt", i), 32'(counter),   32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d.ne", i),  32'(not_empty), 32'(tbl[i].exp_ne));
      chk($sformatf("tbl%0d.udf", i), 32'(underflow), 32'(tbl[i].exp_udf));
    end

    // one full line 0x00..0x3F
    do_reset("seqA");
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, "seqA");
      if (i == 62) chk("seqA.ne_before_last", 32'(not_empty), 32'd0);
    end
    chk("seqA.ne",     32'(not_empty),       32'd1);
    chk("seqA.lane0",  32'(deq_data[7:0]),   32'h00);
    chk("seqA.lane63", 32'(deq_data[511:504]), 32'h3F);
    chk("seqA.cnt",    32'(counter),         32'd64);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "seqA.pop");

    // flush after 10 bytes, then flush together with the 10th byte
    exp_line = '0;
    for (int i = 0; i < 10; i++) exp_line[8*i +: 8] = 8'hA1 + 8'(i);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++)
        cycle(1'b1, 8'hA1 + 8'(i), (pass == 1) && (i == 9), 1'b0, "seqB");
      if (pass == 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, "seqB.flush");
      chk($sformatf("seqB%0d.cnt", pass), 32'(counter), 32'd64);
      chk_line($sformatf("seqB%0d.line", pass), deq_data, exp_line);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, "seqB.pop");
    end

    // fill to capacity, overflow, pop
    do_reset("seqC");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i * 7 + 3), 1'b0, 1'b0, "seqC");
    chk("seqC.not_full", 32'(not_full),   32'd0);
    chk("seqC.free",     32'(free_count), 32'd0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, "seqC.over");
    chk("seqC.ovf",      32'(overflow),   32'd1);
    chk("seqC.cnt_full", 32'(counter),    32'd512);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "seqC.pop");
    chk("seqC.cnt_pop",  32'(counter),    32'd448);

    // down to one line, then 64 cycles of simultaneous enq+deq across wrap
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, "seqD.drain");
    chk("seqD.cnt64", 32'(counter), 32'd64);
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b1, "seqD");
      if (i == 0) chk("seqD.cnt_first", 32'(counter), 32'd1);
    end
    chk("seqD.cnt_end", 32'(counter), 32'd64);
    exp_line = '0;
    for (int i = 0; i < 64; i++) exp_line[8*i +: 8] = 8'h40 + 8'(i);
    chk_line("seqD.wrap_line", deq_data, exp_line);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "seqD.pop");

    // underflow on empty, reset mid-line, pointers back at zero
    do_reset("seqE");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "seqE.udf");
    chk("seqE.udf", 32'(underflow), 32'd1);
    chk("seqE.cnt0", 32'(counter),  32'd0);
    for (int i = 0; i < 37; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, "seqE");
    chk("seqE.cnt37", 32'(counter), 32'd37);
    do_reset("seqE.mid");
    for (int i = 0; i < 64; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, "seqE.refill");
    chk("seqE.lane0",  32'(deq_data[7:0]),     32'hC0);
    chk("seqE.lane63", 32'(deq_data[511:504]), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
